pb_intc: RTL and testbench



---
 rtl/pb_intc_if.sv | 18 +
 rtl/pb_intc.sv | 94 +++++++++
 tb/tb_pb_intc.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pb_intc_if.sv
// pb_intc_if: PicoBlaze port bus (port_id/out_port/in_port strobes) plus interrupt handshake
interface pb_intc_if;
  logic [7:0] port_id;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       read_strobe;
  logic       write_strobe;
  logic       interrupt_ack;
  logic       interrupt;
  modport master (
    output port_id, data_in, read_strobe, write_strobe, interrupt_ack,
    input  data_out, interrupt
  );
  modport slave (
    input  port_id, data_in, read_strobe, write_strobe, interrupt_ack,
    output data_out, interrupt
  );
endinterface

// File: rtl/pb_intc.sv
// pb_intc: PicoBlaze interrupt controller, up to 8 sources onto one CPU interrupt with EOI hold-off.
// Define PB_INTC_ROUND_ROBIN_EN for rotating priority; default is fixed lowest-index priority.
module pb_intc #(
  parameter logic [7:0] BASE_ADDRESS = 8'h80,
  parameter int         NUM_SOURCES  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] irq_in,
  pb_intc_if.slave   bus
);
  localparam logic [7:0] MASK = 8'((9'd1 << NUM_SOURCES) - 9'd1);
  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;
  state_t     state, state_d;
  logic [7:0] pending, pend_d, enable, edge_sel, irq_prev;
  logic [7:0] eligible, rise, w1c, chg, rd_d, off;
  logic [2:0] id, win;
  logic [3:0] first;
  logic       hit, wr, eoi, found, busy;
  logic       unused;
  assign unused   = bus.read_strobe;
  assign off      = bus.port_id - BASE_ADDRESS;
  assign hit      = off < 8'd5;
  assign wr       = bus.write_strobe && hit;
  assign eoi      = wr && off == 8'd4;
  assign busy     = state != IDLE;
  assign eligible = pending & enable;
  assign bus.interrupt = state == ASSERT;
`ifdef PB_INTC_ROUND_ROBIN_EN
  logic [2:0] last_id;
  assign first = {1'b0, last_id} + 4'd1;
  always_ff @(posedge clk) begin
    if (reset) last_id <= 3'(NUM_SOURCES - 1);
    else if (state == SERVICE && eoi) last_id <= id;
  end
`else
  assign first = 4'd0;
`endif
  // Scan NUM_SOURCES slots starting at first, wrapping; first hit wins
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      if (!found && eligible[3'((int'(first) + k) % NUM_SOURCES)]) begin
        win   = 3'((int'(first) + k) % NUM_SOURCES);
        found = 1'b1;
      end
    end
  end
  // Edge bits: set beats W1C; level bits track irq_in; an EDGE_SEL change wipes the changed bits
  always_comb begin
    rise   = irq_in & ~irq_prev;
    w1c    = (wr && off == 8'd0) ? bus.data_in : 8'h00;
    chg    = (wr && off == 8'd2) ? (bus.data_in ^ edge_sel) : 8'h00;
    pend_d = ((edge_sel & ((pending & ~w1c) | rise)) | (~edge_sel & irq_in)) & MASK & ~chg;
  end
  always_comb begin
    rd_d = !hit         ? 8'h00 :
           off == 8'd0  ? pending :
           off == 8'd1  ? enable :
           off == 8'd2  ? edge_sel :
           off == 8'd3  ? {busy, 4'b0, id} : 8'h00;
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = |eligible ? ASSERT : IDLE;
      ASSERT:  state_d = bus.interrupt_ack ? SERVICE : ASSERT;
      SERVICE: state_d = eoi ? IDLE : SERVICE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pending      <= '0;
      enable       <= '0;
      edge_sel     <= '0;
      irq_prev     <= '0;
      id           <= '0;
      bus.data_out <= '0;
    end else begin
      irq_prev     <= irq_in & MASK;
      pending      <= pend_d;
      bus.data_out <= rd_d;
      if (wr && off == 8'd1) enable <= bus.data_in & MASK;
      if (wr && off == 8'd2) edge_sel <= bus.data_in & MASK;
      if (state == IDLE && |eligible) id <= win;
    end
  end
endmodule

// File: tb/tb_pb_intc.sv
// tb_pb_intc: scoreboarded register reads plus direct handshake checks for pb_intc
module tb_pb_intc;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_in;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  pb_intc_if bus();
  pb_intc #(.BASE_ADDRESS(8'h80), .NUM_SOURCES(8)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input string tag, input logic [7:0] addr, input logic [7:0] expv);
    exp_q.push_back(expv);
    bus.port_id     = addr;
    bus.read_strobe = 1'b1;
    tick();
    bus.read_strobe = 1'b0;
    check(tag, {24'h0, bus.data_out}, {24'h0, exp_q.pop_front()});
  endtask
  task automatic wr(input logic [7:0] addr, input logic [7:0] d);
    bus.port_id      = addr;
    bus.data_in      = d;
    bus.write_strobe = 1'b1;
    tick();
    bus.write_strobe = 1'b0;
    bus.port_id      = 8'h00;
  endtask
  task automatic ack();
    bus.interrupt_ack = 1'b1;
    tick();
    bus.interrupt_ack = 1'b0;
  endtask
  task automatic wait_int(input string tag);
    int n = 0;
    while (!bus.interrupt && n < 50) begin
      tick();
      n++;
    end
    if (!bus.interrupt) check(tag, 0, 1);
  endtask
  initial begin
    int bad;
    reset = 1'b1;
    irq_in = '0;
    bus.port_id = '0;
    bus.data_in = '0;
    bus.read_strobe = 1'b0;
    bus.write_strobe = 1'b0;
    bus.interrupt_ack = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_int", bus.interrupt, 0);
    check("rst_dout", bus.data_out, 0);
    for (int a = 0; a < 6; a++) rd($sformatf("rst_reg%0d", a), 8'(8'h80 + a), 8'h00);
`ifdef PB_INTC_ROUND_ROBIN_EN
    wr(8'h81, 8'hFF);
    irq_in = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      wait_int($sformatf("rr_to%0d", i));
      rd($sformatf("rr_vec%0d", i), 8'h83, 8'(8'h80 | (i % 8)));
      ack();
      wr(8'h84, 8'h00);
    end
    irq_in = 8'h00;
`else
    wr(8'h81, 8'h01);
    wr(8'h82, 8'h01);
    irq_in = 8'h01;
    bus.port_id = 8'h80;
    tick();
    irq_in = 8'h00;
    check("int_early", bus.interrupt, 0);
    tick();
    check("edge_pend", bus.data_out, 8'h01);
    check("int_rise", bus.interrupt, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bus.interrupt) bad++;
    end
    check("int_hold", bad, 0);
    ack();
    check("int_drop", bus.interrupt, 0);
    rd("vec_busy", 8'h83, 8'h80);
    wr(8'h80, 8'h00);
    wr(8'h84, 8'h00);
    rd("vec_eoi", 8'h83, 8'h00);
    wr(8'h80, 8'h01);
    rd("w1c_pend", 8'h80, 8'h00);
    check("rearm", bus.interrupt, 1);
    ack();
    wr(8'h84, 8'h00);
    wr(8'h82, 8'h00);
    wr(8'h81, 8'h06);
    irq_in = 8'h06;
    wait_int("lvl_to1");
    rd("lvl_vec1", 8'h83, 8'h81);
    ack();
    wr(8'h84, 8'h00);
    wait_int("lvl_to2");
    rd("lvl_vec2", 8'h83, 8'h81);
    ack();
    wr(8'h80, 8'h02);
    rd("lvl_nw1c", 8'h80, 8'h06);
    irq_in = 8'h04;
    wr(8'h84, 8'h00);
    wait_int("lvl_to3");
    rd("lvl_vec3", 8'h83, 8'h82);
    ack();
    irq_in = 8'h00;
    wr(8'h84, 8'h00);
    wr(8'h81, 8'h00);
    irq_in = 8'hFF;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.interrupt) bad++;
    end
    check("dis_noint", bad, 0);
    wr(8'h81, 8'h08);
    wait_int("en_to");
    rd("en_vec", 8'h83, 8'h83);
    ack();
    irq_in = 8'h00;
    wr(8'h84, 8'h00);
    wr(8'h81, 8'h00);
    wr(8'h82, 8'h08);
    tick();
    irq_in = 8'h08;
    tick();
    irq_in = 8'h00;
    rd("e3_pend", 8'h80, 8'h08);
    irq_in = 8'h08;
    wr(8'h80, 8'h08);
    irq_in = 8'h00;
    rd("setwins", 8'h80, 8'h08);
    wr(8'h80, 8'h08);
    rd("w1c3", 8'h80, 8'h00);
    irq_in = 8'h08;
    tick();
    irq_in = 8'h00;
    wr(8'h81, 8'h08);
    wait_int("svc_to");
    ack();
    rd("svc_vec", 8'h83, 8'h83);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_int", bus.interrupt, 0);
    check("mrst_dout", bus.data_out, 0);
    rd("mrst_vec", 8'h83, 8'h00);
    rd("mrst_en", 8'h81, 8'h00);
    rd("mrst_es", 8'h82, 8'h00);
    rd("mrst_pend", 8'h80, 8'h00);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
